// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the UART debug command master and responder-side handlers.
package dbg_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_TXWAIT,
    S_RXWAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TIMEOUT  = 2'd1;
  localparam logic [1:0] ST_OVERFLOW = 2'd2;

  // Upper opcode nibble selects the command class.
  localparam logic [3:0] OP_CPU_CTL  = 4'h0;
  localparam logic [3:0] OP_PING     = 4'h1;
  localparam logic [3:0] OP_REG_READ = 4'h2;

  function automatic logic [1:0] end_status(input logic timeout, input logic ovf);
    if (timeout)  return ST_TIMEOUT;
    else if (ovf) return ST_OVERFLOW;
    else          return ST_OK;
  endfunction

endpackage

// File: rtl/dbg_rsp_fifo.sv
// Response byte FIFO; a push into a full FIFO only lands if a pop happens in the same cycle.
module dbg_rsp_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wp, rp;
  logic              do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the output is clean out of reset.
  assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dbg_cmd_master.sv
// Debug protocol initiator: sends one opcode byte, gathers a fixed number of response
// bytes under an inactivity timeout, and reports completion with a status pulse.
module dbg_cmd_master
  import dbg_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_opcode,
  input  logic [2:0] req_rsp_len,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready,
  output logic       done,
  output logic [1:0] status,
  output logic       stray
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [2:0]    remaining;
  logic          busy_seen;
  logic          ovf;
  logic [CW-1:0] idle_cnt;

  logic accept, last_byte, drop, expire, fifo_full, fifo_empty;

  // Bytes count toward the response while the opcode is still shifting out, too.
  assign accept    = rx_en && (state == S_TXWAIT || state == S_RXWAIT) && (remaining != 3'd0);
  assign last_byte = accept && (remaining == 3'd1);
  assign drop      = accept && fifo_full && !(rsp_ready && rsp_valid);
  assign expire    = (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_valid = !fifo_empty;

  dbg_rsp_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (rx_data),
    .pop   (rsp_ready),
    .rdata (rsp_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      tx_data   <= '0;
      tx_en     <= 1'b0;
      done      <= 1'b0;
      status    <= ST_OK;
      stray     <= 1'b0;
      remaining <= '0;
      busy_seen <= 1'b0;
      ovf       <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      tx_en <= 1'b0;
      done  <= 1'b0;
      stray <= rx_en && !accept;
      if (accept) remaining <= remaining - 3'd1;
      if (drop)   ovf <= 1'b1;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            tx_data   <= req_opcode;
            remaining <= req_rsp_len;
            ovf       <= 1'b0;
            req_ready <= 1'b0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_en     <= 1'b1;
            busy_seen <= 1'b0;
            idle_cnt  <= '0;
            state     <= S_TXWAIT;
          end
        end
        S_TXWAIT: begin
          busy_seen <= busy_seen | tx_busy;
          if (busy_seen && !tx_busy) begin
            idle_cnt <= '0;
            if (remaining == 3'd0 || last_byte) begin
              done   <= 1'b1;
              status <= end_status(1'b0, ovf | drop);
              state  <= S_DONE;
            end else begin
              state <= S_RXWAIT;
            end
          end else if (accept || (tx_busy && !busy_seen)) begin
            idle_cnt <= '0;
          end else if (expire) begin
            done   <= 1'b1;
            status <= end_status(1'b1, ovf);
            state  <= S_DONE;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        S_RXWAIT: begin
          // A byte arriving in the expiry cycle takes precedence over the timeout.
          if (accept) begin
            idle_cnt <= '0;
            if (last_byte) begin
              done   <= 1'b1;
              status <= end_status(1'b0, ovf | drop);
              state  <= S_DONE;
            end
          end else if (expire) begin
            done   <= 1'b1;
            status <= end_status(1'b1, ovf);
            state  <= S_DONE;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        S_DONE: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
